utopia_rx_cell_assembler: RTL and testbench

Utopia Level-1 receive-side cell assembler. It pulls 53-byte ATM cells octet by octet from a PHY-side Utopia receive port using the clav/en/soc/data handshake. It checks the header HEC, packs each good cell into a single parallel word, and hands it to the core receive logic through a valid/ready handshake. It sits between the PHY byte bus and the ATMcell/valid/ready side consumed by the core receive path.

---
 rtl/utopia_rx_cell_assembler_if.sv | 26 ++
 rtl/utopia_rx_cell_assembler.sv | 172 +++++++++++++++++
 tb/tb_utopia_rx_cell_assembler.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/utopia_rx_cell_assembler_if.sv
// Bundles the Utopia receive byte bus (PHY side) and the assembled-cell
// valid/ready bus (core side). The assembler uses the slave view.
interface utopia_rx_cell_assembler_if #(
  parameter int IfWidth = 8
) ();
  logic                   clav;
  logic                   soc;
  logic [IfWidth-1:0]     data;
  logic                   en;
  logic [53*IfWidth-1:0]  ATMcell;
  logic                   valid;
  logic                   ready;

  // Byte transfer: a byte moves on a rising edge where en==0 and clav==1.
  // Cell transfer: ATMcell moves on a rising edge where valid==1 and ready==1;
  // once valid is high, ATMcell and valid hold until that edge.
  modport slave (
    input  clav, soc, data, ready,
    output en, ATMcell, valid
  );

  modport master (
    output clav, soc, data, ready,
    input  en, ATMcell, valid
  );
endinterface

// File: rtl/utopia_rx_cell_assembler.sv
// Utopia Level-1 receive cell assembler: pulls 53 octets from the PHY, checks
// the header HEC, and presents the whole cell as one word on a valid/ready bus.
module utopia_rx_cell_assembler #(
  parameter int          IfWidth  = 8,
  parameter logic [7:0]  HecCoset = 8'h55,
  parameter bit          HecCheck = 1'b1,
  parameter int          CntWidth = 16
) (
  input  logic                 clk_in,
  input  logic                 reset,
  utopia_rx_cell_assembler_if.slave bus,
  output logic                 hec_err,
  output logic                 runt_err,
  output logic [CntWidth-1:0]  cell_cnt,
  output logic [CntWidth-1:0]  err_cnt,
  output logic [1:0]           dbg_state_o
);

  localparam int CellW = 53 * IfWidth;
  localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [7:0]           crc_q, crc_d;
  logic                 bad_q, bad_d;
  logic                 en_q, en_d;
  logic                 valid_q, valid_d;
  logic [CellW-1:0]     cell_q, cell_d;
  logic                 hec_q, hec_d;
  logic                 runt_q, runt_d;
  logic [CntWidth-1:0]  cell_cnt_q, cell_cnt_d;
  logic [CntWidth-1:0]  err_cnt_q, err_cnt_d;
  logic                 accept;

  // One octet of CRC-8 (x^8+x^2+x+1), MSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  assign accept = !en_q && bus.clav;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    bad_d      = bad_q;
    en_d       = en_q;
    valid_d    = valid_q;
    cell_d     = cell_q;
    hec_d      = 1'b0;
    runt_d     = 1'b0;
    cell_cnt_d = cell_cnt_q;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      IDLE: begin
        en_d    = 1'b1;
        valid_d = 1'b0;
        if (bus.clav) begin
          state_d = RECV;
          en_d    = 1'b0;
          cnt_d   = 6'd0;
          crc_d   = 8'h00;
          bad_d   = 1'b0;
        end
      end

      RECV: begin
        if (accept) begin
          if (cnt_q == 6'd0 && !bus.soc) begin
            // Stray octet outside a cell: keep hunting for soc.
            cnt_d = 6'd0;
          end else if (cnt_q != 6'd0 && bus.soc) begin
            runt_d = 1'b1;
            cell_d = {cell_q[CellW-IfWidth-1:0], bus.data};
            cnt_d  = 6'd1;
            crc_d  = crc8_step(8'h00, bus.data);
            bad_d  = 1'b0;
          end else begin
            cell_d = {cell_q[CellW-IfWidth-1:0], bus.data};
            cnt_d  = cnt_q + 6'd1;
            if (cnt_q < 6'd4) begin
              crc_d = crc8_step(crc_q, bus.data);
            end
            if (cnt_q == 6'd4 && ((crc_q ^ HecCoset) != bus.data)) begin
              bad_d = 1'b1;
            end
            if (cnt_q == 6'd52) begin
              en_d  = 1'b1;
              cnt_d = 6'd0;
              hec_d = bad_q;
              if (bad_q && HecCheck) begin
                state_d = IDLE;
              end else begin
                state_d = HOLD;
                valid_d = 1'b1;
              end
            end
          end
        end
      end

      HOLD: begin
        en_d = 1'b1;
        if (valid_q && bus.ready) begin
          state_d    = IDLE;
          valid_d    = 1'b0;
          cell_cnt_d = cell_cnt_q + CntOne;
        end
      end

      default: begin
        state_d = IDLE;
        en_d    = 1'b1;
        valid_d = 1'b0;
      end
    endcase

    if ((hec_d || runt_d) && (err_cnt_q != {CntWidth{1'b1}})) begin
      err_cnt_d = err_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 6'd0;
      crc_q      <= 8'h00;
      bad_q      <= 1'b0;
      en_q       <= 1'b1;
      valid_q    <= 1'b0;
      cell_q     <= '0;
      hec_q      <= 1'b0;
      runt_q     <= 1'b0;
      cell_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      bad_q      <= bad_d;
      en_q       <= en_d;
      valid_q    <= valid_d;
      cell_q     <= cell_d;
      hec_q      <= hec_d;
      runt_q     <= runt_d;
      cell_cnt_q <= cell_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.en      = en_q;
  assign bus.valid   = valid_q;
  assign bus.ATMcell = cell_q;
  assign hec_err     = hec_q;
  assign runt_err    = runt_q;
  assign cell_cnt    = cell_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_utopia_rx_cell_assembler.sv
// Self-checking bench for utopia_rx_cell_assembler: directed scenarios plus a
// randomized run, scored against a cell-level reference model.
module tb_utopia_rx_cell_assembler;

  localparam int CW = 424;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        hec_err, runt_err;
  logic [15:0] cell_cnt, err_cnt;
  logic [1:0]  dbg_state;

  utopia_rx_cell_assembler_if #(.IfWidth(8)) u_if ();

  utopia_rx_cell_assembler #(
    .IfWidth(8), .HecCoset(8'h55), .HecCheck(1'b1), .CntWidth(16)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .bus         (u_if),
    .hec_err     (hec_err),
    .runt_err    (runt_err),
    .cell_cnt    (cell_cnt),
    .err_cnt     (err_cnt),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  longint cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int            n_cmp = 0;
  int            n_fail = 0;
  logic [CW-1:0] exp_q[$];
  int            mdl_cells = 0, mdl_errs = 0;
  int            exp_hec = 0, exp_runt = 0;
  int            seen_hec = 0, seen_runt = 0;
  int            hold_len = 0;
  int            gap_cnt = 0;
  longint        last_rise = -1;
  bit            chk_gap = 0;
  bit            rnd_ready = 0;
  logic [7:0]    cb[53];

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_cell(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // HEC as polynomial remainder of header*x^8 modulo x^8+x^2+x+1, plus coset.
  function automatic logic [7:0] ref_hec(input logic [31:0] hdr);
    logic [39:0] r;
    r = {hdr, 8'h00};
    for (int i = 39; i >= 8; i--) begin
      if (r[i]) r = r ^ (40'h107 << (i - 8));
    end
    return r[7:0] ^ 8'h55;
  endfunction

  function automatic logic [CW-1:0] pack_cell();
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < 53; i++) c[CW-1-8*i -: 8] = cb[i];
    return c;
  endfunction

  task automatic model_cell();
    if (ref_hec({cb[0], cb[1], cb[2], cb[3]}) == cb[4]) begin
      exp_q.push_back(pack_cell());
      mdl_cells++;
    end else begin
      exp_hec++;
      mdl_errs++;
    end
  endtask

  task automatic build_random(input bit bad);
    for (int i = 0; i < 4; i++) cb[i] = 8'($urandom_range(0, 255));
    cb[4] = ref_hec({cb[0], cb[1], cb[2], cb[3]});
    if (bad) cb[4] = cb[4] ^ (8'h01 << $urandom_range(0, 7));
    for (int i = 5; i < 53; i++) cb[i] = 8'($urandom_range(0, 255));
  endtask

  // ---------------- monitor ----------------
  logic          prev_valid = 1'b0;
  logic [CW-1:0] held;
  int            vlen = 0;

  always @(negedge clk_in) begin
    if (reset) begin
      prev_valid = 1'b0;
      vlen = 0;
    end else begin
      if (hec_err) seen_hec++;
      if (runt_err) seen_runt++;
      if (u_if.valid) begin
        if (!prev_valid) begin
          vlen = 0;
          held = u_if.ATMcell;
          if (chk_gap && last_rise >= 0) begin
            gap_cnt++;
            n_cmp++;
            if ((cyc - last_rise) < 55 || (cyc - last_rise) > 56) begin
              n_fail++;
              $display("FAIL b2b_gap: got %0d cycles expected 55..56", cyc - last_rise);
            end
          end
          last_rise = cyc;
        end else begin
          check_cell("hold_stable", u_if.ATMcell, held);
        end
        check_int("en_high_in_hold", int'(u_if.en), 1);
        vlen++;
        if (u_if.ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_cell: got %h expected none", u_if.ATMcell);
          end else begin
            check_cell("cell", u_if.ATMcell, exp_q.pop_front());
          end
        end
      end else if (prev_valid) begin
        hold_len = vlen;
      end
      prev_valid = u_if.valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_in);
    #2;
    if (rnd_ready) u_if.ready = 1'($urandom_range(0, 1));
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      step();
      u_if.clav = 1'b0;
    end
  endtask

  task automatic push_byte(input logic s, input logic [7:0] d);
    int   t;
    logic acc;
    t = 0;
    acc = 1'b0;
    while (!acc && t < 300) begin
      step();
      u_if.clav = 1'b1;
      u_if.soc  = s;
      u_if.data = d;
      acc = !u_if.en;
      t++;
    end
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL byte_timeout: got no accept expected accept within 300 cycles");
    end
  endtask

  task automatic send_cell(input int nbytes, input int stall_at, input int stall_len, input bit rnd_stall);
    for (int i = 0; i < nbytes; i++) begin
      if (i == stall_at) stall(stall_len);
      if (rnd_stall && $urandom_range(0, 7) == 0) stall($urandom_range(1, 3));
      push_byte(i == 0, cb[i]);
    end
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    u_if.clav = 1'b0;
    step();
    check_int("rst_en", int'(u_if.en), 1);
    check_int("rst_valid", int'(u_if.valid), 0);
    check_cell("rst_cell", u_if.ATMcell, '0);
    check_int("rst_hec_err", int'(hec_err), 0);
    check_int("rst_runt_err", int'(runt_err), 0);
    check_int("rst_cell_cnt", int'(cell_cnt), 0);
    check_int("rst_err_cnt", int'(err_cnt), 0);
    check_int("rst_state", int'(dbg_state), 0);
    reset = 1'b0;
    exp_q.delete();
    mdl_cells = 0;
    mdl_errs = 0;
  endtask

  task automatic drain_and_check(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || dbg_state != 2'd0) && t < 400) begin
      step();
      u_if.clav = 1'b0;
      t++;
    end
    stall(2);
    check_int({tag, "_drained"}, exp_q.size(), 0);
    check_int({tag, "_cell_cnt"}, int'(cell_cnt), mdl_cells);
    check_int({tag, "_err_cnt"}, int'(err_cnt), mdl_errs);
    check_int({tag, "_hec_pulses"}, seen_hec, exp_hec);
    check_int({tag, "_runt_pulses"}, seen_runt, exp_runt);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    reset = 1'b1;
    u_if.clav = 1'b0;
    u_if.soc = 1'b0;
    u_if.data = 8'h00;
    u_if.ready = 1'b0;
    repeat (3) @(posedge clk_in);

    // Good cell with a zero header and incrementing payload.
    do_reset();
    u_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) cb[i] = 8'h00;
    cb[4] = 8'h55;
    for (int i = 5; i < 53; i++) cb[i] = 8'(i - 4);
    model_cell();
    check_int("hdr_model_ok", exp_q.size(), 1);
    send_cell(53, -1, 0, 0);
    drain_and_check("good");
    check_int("good_valid_len", hold_len, 1);

    // Bad HEC: cell consumed and dropped.
    do_reset();
    cb[4] = 8'h54;
    model_cell();
    send_cell(53, -1, 0, 0);
    drain_and_check("badhec");
    check_int("badhec_en_idle", int'(u_if.en), 1);

    // soc reasserted at byte 20, then a full good cell.
    do_reset();
    build_random(0);
    send_cell(20, -1, 0, 0);
    build_random(0);
    exp_runt++;
    mdl_errs++;
    model_cell();
    send_cell(53, -1, 0, 0);
    drain_and_check("runt");

    // clav stall at byte 30, ready held low for 10 cycles of valid.
    do_reset();
    u_if.ready = 1'b0;
    build_random(0);
    model_cell();
    send_cell(53, 30, 5, 0);
    t = 0;
    while (!u_if.valid && t < 20) begin
      step();
      u_if.clav = 1'b0;
      t++;
    end
    check_int("stall_valid_seen", int'(u_if.valid), 1);
    repeat (10) begin
      step();
      u_if.clav = 1'b0;
    end
    u_if.ready = 1'b1;
    drain_and_check("stall");
    check_int("stall_valid_len", hold_len, 11);

    // Reset at byte 40, then a good cell.
    do_reset();
    build_random(0);
    send_cell(40, -1, 0, 0);
    do_reset();
    build_random(0);
    model_cell();
    send_cell(53, -1, 0, 0);
    drain_and_check("midreset");

    // Three back-to-back cells with clav and ready held high.
    do_reset();
    chk_gap = 1'b1;
    last_rise = -1;
    gap_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      build_random(0);
      model_cell();
      send_cell(53, -1, 0, 0);
    end
    drain_and_check("b2b");
    chk_gap = 1'b0;
    check_int("b2b_gap_count", gap_cnt, 2);

    // Randomized cells: random headers, ~1/4 bad HEC, random stalls and ready.
    do_reset();
    rnd_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      build_random($urandom_range(0, 3) == 0);
      model_cell();
      send_cell(53, -1, 0, 1);
    end
    rnd_ready = 1'b0;
    u_if.ready = 1'b1;
    drain_and_check("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
